rng_bus_scheduler: RTL and testbench

- Bus master sitting in front of the LCG random-number peripheral. It has two jobs:
  - shares the peripheral's output word between NUM_REQ requesters using round-robin arbitration;
  - loads seed, multiplier and increment through the peripheral's six config registers.
- Drives the peripheral's bus (cyc/stb/we/sel/adr/dat_w, with dat_r/ack returned). It is the only master on that bus.

---
 rtl/rng_bus_scheduler_if.sv | 15 +
 rtl/rng_bus_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_rng_bus_scheduler.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_bus_scheduler_if.sv
`timescale 1ns/1ps
// Bus between the scheduler (sole master) and the LCG random-number peripheral.
interface rng_bus_scheduler_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/rng_bus_scheduler.sv
`timescale 1ns/1ps
// Shares the LCG peripheral's output word between NUM_REQ requesters (round robin)
// and loads seed/mult/inc through its six config registers, with an ack timeout.
module rng_bus_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  input  logic               cfg_start,
  input  logic [63:0]        cfg_seed,
  input  logic [63:0]        cfg_mult,
  input  logic [63:0]        cfg_inc,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_err,
  rng_bus_scheduler_if.master m
);

  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned NUM_WORDS = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_BUS = 2'd1,
    WR_BUS = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [ID_W-1:0]    arb_id;
  logic               arb_hit;
  logic [NUM_REQ-1:0] arb_req;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        seed_q, seed_d;
  logic [63:0]        mult_q, mult_d;
  logic [63:0]        inc_q, inc_d;
  logic               launch;

  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [31:0]        rsp_data_d;
  logic               rsp_err_d;
  logic               cfg_busy_d;
  logic               cfg_done_d;
  logic               cfg_err_d;
  logic               cyc_d, stb_d, we_d, sel_d;
  logic [31:0]        adr_d;
  logic [31:0]        dat_w_d;

  // Config register word order: high half before low half, seed/mult/inc.
  function automatic logic [31:0] cfg_word(input logic [IDX_W-1:0] i,
                                           input logic [63:0] s,
                                           input logic [63:0] mu,
                                           input logic [63:0] in);
    case (i)
      3'd0:    cfg_word = s[63:32];
      3'd1:    cfg_word = s[31:0];
      3'd2:    cfg_word = mu[63:32];
      3'd3:    cfg_word = mu[31:0];
      3'd4:    cfg_word = in[63:32];
      default: cfg_word = in[31:0];
    endcase
  endfunction

  // Round robin from ptr+1; rsp_valid is only non-zero in a read's GAP cycle,
  // which masks the requester just served so it can drop req.
  always_comb begin
    arb_req = req & ~rsp_valid;
    arb_hit = 1'b0;
    arb_id  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!arb_hit && arb_req[ID_W'((32'(ptr_q) + k) % NUM_REQ)]) begin
        arb_hit = 1'b1;
        arb_id  = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    mult_d      = mult_q;
    inc_d       = inc_q;
    launch      = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = 1'b0;
    cfg_busy_d  = cfg_busy;
    cfg_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    cyc_d       = 1'b0;
    stb_d       = 1'b0;
    we_d        = 1'b0;
    sel_d       = 1'b0;
    adr_d       = '0;
    dat_w_d     = '0;

    case (state_q)
      IDLE: launch = 1'b1;

      RD_BUS: begin
        if (m.ack) begin
          rsp_valid_d = NUM_REQ'(1) << gid_q;
          rsp_data_d  = m.dat_r;
          state_d     = GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = NUM_REQ'(1) << gid_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = GAP;
        end else begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          sel_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WR_BUS: begin
        if (m.ack) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = GAP;
          if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            cfg_done_d = 1'b1;
            cfg_busy_d = 1'b0;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cfg_err_d  = 1'b1;
          cfg_busy_d = 1'b0;
          state_d    = GAP;
        end else begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 1'b1;
          adr_d   = m.adr;
          dat_w_d = m.dat_w;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cfg_busy) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = 1'b1;
          adr_d   = 32'(idx_q) + 32'd1;
          dat_w_d = cfg_word(idx_q, seed_q, mult_q, inc_q);
          cnt_d   = '0;
          state_d = WR_BUS;
        end else begin
          launch = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared by IDLE and a free GAP: config wins over reads.
    if (launch) begin
      state_d = IDLE;
      if (cfg_start) begin
        seed_d     = cfg_seed;
        mult_d     = cfg_mult;
        inc_d      = cfg_inc;
        cfg_busy_d = 1'b1;
        idx_d      = '0;
        cnt_d      = '0;
        cyc_d      = 1'b1;
        stb_d      = 1'b1;
        we_d       = 1'b1;
        sel_d      = 1'b1;
        adr_d      = 32'd1;
        dat_w_d    = cfg_seed[63:32];
        state_d    = WR_BUS;
      end else if (arb_hit) begin
        gid_d   = arb_id;
        ptr_d   = arb_id;
        cnt_d   = '0;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        sel_d   = 1'b1;
        state_d = RD_BUS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      gid_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      seed_q    <= '0;
      mult_q    <= '0;
      inc_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      m.cyc     <= 1'b0;
      m.stb     <= 1'b0;
      m.we      <= 1'b0;
      m.sel     <= 1'b0;
      m.adr     <= '0;
      m.dat_w   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      seed_q    <= seed_d;
      mult_q    <= mult_d;
      inc_q     <= inc_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      cfg_busy  <= cfg_busy_d;
      cfg_done  <= cfg_done_d;
      cfg_err   <= cfg_err_d;
      m.cyc     <= cyc_d;
      m.stb     <= stb_d;
      m.we      <= we_d;
      m.sel     <= sel_d;
      m.adr     <= adr_d;
      m.dat_w   <= dat_w_d;
    end
  end

endmodule

// File: tb/tb_rng_bus_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for rng_bus_scheduler: directed stimulus pushes expected
// responses/writes/config pulses; a negedge monitor pops and compares them.
module tb_rng_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        cfg_start = 1'b0;
  logic [63:0] cfg_seed = '0, cfg_mult = '0, cfg_inc = '0;
  logic        cfg_busy, cfg_done, cfg_err;

  rng_bus_scheduler_if bus ();

  rng_bus_scheduler #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .cfg_start(cfg_start), .cfg_seed(cfg_seed), .cfg_mult(cfg_mult),
    .cfg_inc(cfg_inc), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .m(bus)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave: registered ack, read data = base + number of completed reads.
  logic        never_ack = 1'b0;
  logic [31:0] noack_adr = '0;
  logic [31:0] rd_base = 32'hDEADBEEF;
  int          rd_count = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.ack <= 1'b0;
    else      bus.ack <= bus.cyc && bus.stb && !never_ack && !(bus.we && bus.adr == noack_adr);
  end
  always @(posedge clk) if (bus.cyc && !bus.we && bus.ack) rd_count <= rd_count + 1;
  assign bus.dat_r = rd_base + 32'(rd_count);

  typedef struct { logic [3:0] valid; logic err; logic [31:0] data; int at; } rsp_t;
  typedef struct { logic [31:0] adr; logic [31:0] dat; int at; } wr_t;
  typedef struct { logic done; logic err; int at; } cfg_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  cfg_t cfg_q[$];

  int total = 0;
  int bad   = 0;
  int exp_rd = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endfunction

  function automatic void fail(input string name, input int info);
    total++;
    bad++;
    $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc_n);
  endfunction

  function automatic void push_rd(input logic [3:0] v, input int at);
    rsp_q.push_back('{v, 1'b0, rd_base + 32'(exp_rd), at});
    exp_rd++;
  endfunction

  // Six writes plus the closing cfg pulse, for a start driven in cycle n.
  function automatic void push_cfg(input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2, input logic [31:0] w3,
                                   input logic [31:0] w4, input logic [31:0] w5,
                                   input int n);
    logic [31:0] w [6];
    w = '{w0, w1, w2, w3, w4, w5};
    for (int i = 0; i < 6; i++) wr_q.push_back('{32'(i + 1), w[i], n + 2 + 3 * i});
    cfg_q.push_back('{1'b1, 1'b0, n + 18});
  endfunction

  // Monitor
  initial begin
    rsp_t r;
    wr_t  w;
    cfg_t c;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rsp_valid != '0) begin
          check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
          check("rsp_cyc_low", 32'(bus.cyc), 32'd0);
          if (rsp_q.size() == 0) fail("rsp_unexpected", int'(rsp_valid));
          else begin
            r = rsp_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(r.valid));
            check("rsp_err", 32'(rsp_err), 32'(r.err));
            check("rsp_data", rsp_data, r.data);
            check("rsp_cycle", 32'(cyc_n), 32'(r.at));
          end
        end
        if (cfg_done || cfg_err) begin
          check("cfg_busy_clear", 32'(cfg_busy), 32'd0);
          if (cfg_q.size() == 0) fail("cfg_unexpected", int'({cfg_done, cfg_err}));
          else begin
            c = cfg_q.pop_front();
            check("cfg_done", 32'(cfg_done), 32'(c.done));
            check("cfg_err", 32'(cfg_err), 32'(c.err));
            check("cfg_cycle", 32'(cyc_n), 32'(c.at));
          end
        end
        if (bus.cyc && bus.we && bus.ack) begin
          check("wr_sel", 32'(bus.sel), 32'd1);
          if (wr_q.size() == 0) fail("wr_unexpected", int'(bus.adr));
          else begin
            w = wr_q.pop_front();
            check("wr_adr", bus.adr, w.adr);
            check("wr_dat", bus.dat_w, w.dat);
            check("wr_cycle", 32'(cyc_n), 32'(w.at));
          end
        end
      end
    end
  end

  task automatic wait_bit(input int b, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (rsp_valid[b]) got = 1'b1;
    end
    if (!got) fail("wait_rsp", b);
  endtask

  task automatic wait_idle();
    bit empty = 1'b0;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(negedge clk);
      empty = (rsp_q.size() == 0) && (wr_q.size() == 0) && (cfg_q.size() == 0) && !bus.cyc;
    end
    if (!empty) fail("drain", rsp_q.size() + wr_q.size() + cfg_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int n;
    int got;
    logic [31:0] maxa;

    repeat (2) @(negedge clk);
    check("reset_rsp", {28'd0, rsp_valid}, 32'd0);
    check("reset_data", rsp_data, 32'd0);
    check("reset_flags", 32'({rsp_err, cfg_busy, cfg_done, cfg_err}), 32'd0);
    check("reset_ctrl", 32'({bus.cyc, bus.stb, bus.we, bus.sel}), 32'd0);
    check("reset_adr", bus.adr, 32'd0);
    check("reset_datw", bus.dat_w, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single read, DEADBEEF
    n = cyc_n;
    req = 4'b0001;
    push_rd(4'b0001, n + 3);
    @(negedge clk);
    check("t2_cyc1", 32'(bus.cyc), 32'd1);
    @(negedge clk);
    check("t2_cyc2_ack", 32'({bus.cyc, bus.ack}), 32'd3);
    wait_bit(0, 10);
    req = 4'b0000;
    wait_idle();

    // Round robin, 12 reads from reset
    reset_dut();
    n = cyc_n;
    req = 4'b1111;
    for (int k = 0; k < 12; k++) push_rd(4'(1 << (k % 4)), n + 3 + 3 * k);
    got = 0;
    for (int k = 0; k < 60 && got < 12; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) got++;
    end
    req = 4'b0000;
    if (got != 12) fail("t3_count", got);
    wait_idle();

    // Config load, req raised mid-sequence
    n = cyc_n;
    cfg_seed = 64'h123456789ABCDEF0;
    cfg_mult = 64'h5851F42D4C957F2D;
    cfg_inc  = 64'h14057B7EF767814F;
    cfg_start = 1'b1;
    push_cfg(32'h12345678, 32'h9ABCDEF0, 32'h5851F42D, 32'h4C957F2D,
             32'h14057B7E, 32'hF767814F, n);
    @(negedge clk);
    cfg_start = 1'b0;
    check("t4_busy", 32'(cfg_busy), 32'd1);
    repeat (4) @(negedge clk);
    req = 4'b0010;
    push_rd(4'b0010, n + 21);
    wait_bit(1, 40);
    req = 4'b0000;
    wait_idle();

    // cfg_start and req together: config first
    n = cyc_n;
    cfg_seed = 64'h0011223344556677;
    cfg_mult = 64'h8899AABBCCDDEEFF;
    cfg_inc  = 64'hCAFEF00D00000001;
    cfg_start = 1'b1;
    req = 4'b0001;
    push_cfg(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
             32'hCAFEF00D, 32'h00000001, n);
    push_rd(4'b0001, n + 21);
    @(negedge clk);
    cfg_start = 1'b0;
    wait_bit(0, 40);
    req = 4'b0000;
    wait_idle();

    // Read timeout
    never_ack = 1'b1;
    n = cyc_n;
    req = 4'b0100;
    rsp_q.push_back('{4'b0100, 1'b1, 32'd0, n + 16});
    repeat (15) @(negedge clk);
    check("t6_cyc_last", 32'(bus.cyc), 32'd1);
    wait_bit(2, 5);
    req = 4'b0000;
    never_ack = 1'b0;
    wait_idle();

    // Config timeout at adr 3
    noack_adr = 32'd3;
    n = cyc_n;
    cfg_seed = 64'h123456789ABCDEF0;
    cfg_mult = 64'h5851F42D4C957F2D;
    cfg_inc  = 64'h14057B7EF767814F;
    cfg_start = 1'b1;
    wr_q.push_back('{32'd1, 32'h12345678, n + 2});
    wr_q.push_back('{32'd2, 32'h9ABCDEF0, n + 5});
    cfg_q.push_back('{1'b0, 1'b1, n + 22});
    maxa = '0;
    @(negedge clk);
    cfg_start = 1'b0;
    if (bus.cyc && bus.adr > maxa) maxa = bus.adr;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.cyc && bus.adr > maxa) maxa = bus.adr;
    end
    check("t6b_max_adr", maxa, 32'd3);
    check("t6b_busy", 32'(cfg_busy), 32'd0);
    noack_adr = '0;
    wait_idle();

    // Async reset mid-read; held request is served after release
    n = cyc_n;
    req = 4'b0001;
    @(negedge clk);
    check("t7_cyc_before", 32'(bus.cyc), 32'd1);
    rst = 1'b0;
    #1;
    check("t7_ctrl_async", 32'({bus.cyc, bus.stb, bus.sel, cfg_busy}), 32'd0);
    check("t7_rsp_async", {28'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n = cyc_n;
    push_rd(4'b0001, n + 3);
    rst = 1'b1;
    wait_bit(0, 10);
    req = 4'b0000;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
